// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: registered valid/ready decode stage between fetch and execute.
// Decodes opcode/aluop into a registered control word. Mul/div requests occupy the
// stage for MD_LAT cycles before their word issues. Flush kills held or in-flight work.
// Optional load-use interlock: define DECODE_HAZARD_EN to enable it.
module decode_ctrl_pipe #(
    parameter int REGW   = 5,
    parameter int MD_LAT = 32,
    parameter int CNTW   = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      opcode,
    input  logic [4:0]      aluop,
    input  logic [REGW-1:0] rd,
    input  logic [REGW-1:0] rs,
    input  logic [REGW-1:0] rt,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            Rwe,
    output logic            Rst,
    output logic            ALUinB,
    output logic            DMwe,
    output logic            Rwd,
    output logic [4:0]      alu_ctrl,
    output logic            j,
    output logic            bne,
    output logic            jal,
    output logic            jr,
    output logic            blt,
    output logic            bex,
    output logic            setx,
    output logic            md_start,
    output logic            illegal,
    output logic [REGW-1:0] rd_q,
    output logic [REGW-1:0] rs_q,
    output logic [REGW-1:0] rt_q
);

    typedef enum logic [1:0] {IDLE, MD_WAIT, STALL} state_t;

    state_t            state;
    logic [CNTW-1:0]   md_cnt;
    logic [4:0]        md_aluop;
    logic [REGW-1:0]   md_rd, md_rs, md_rt;
    logic              run_q;

    logic       d_rwe, d_rst, d_alub, d_dmwe, d_rwd;
    logic       d_j, d_bne, d_jal, d_jr, d_blt, d_bex, d_setx, d_ill;
    logic [4:0] d_alu;
    logic       is_md, is_lw;
    logic       hazard, slot_free, fire, out_fire, word_load, md_load;

    // Combinational decode of the presented opcode/aluop into a candidate control word
    always_comb begin
        d_rwe  = 1'b0;
        d_rst  = 1'b0;
        d_alub = 1'b0;
        d_dmwe = 1'b0;
        d_rwd  = 1'b0;
        d_j    = 1'b0;
        d_bne  = 1'b0;
        d_jal  = 1'b0;
        d_jr   = 1'b0;
        d_blt  = 1'b0;
        d_bex  = 1'b0;
        d_setx = 1'b0;
        d_ill  = 1'b0;
        d_alu  = aluop;
        case (opcode)
            5'b00000: begin
                if (aluop <= 5'd7) d_rwe = 1'b1;
                else               d_ill = 1'b1;
            end
            5'b00001: d_j = 1'b1;
            5'b00010: begin d_bne = 1'b1; d_rst = 1'b1; d_alu = 5'd1; end
            5'b00011: begin d_jal = 1'b1; d_rwe = 1'b1; end
            5'b00100: begin d_jr = 1'b1; d_rst = 1'b1; end
            5'b00101: begin d_alub = 1'b1; d_rwe = 1'b1; d_alu = 5'd0; end
            5'b00110: begin d_blt = 1'b1; d_rst = 1'b1; d_alu = 5'd1; end
            5'b00111: begin d_dmwe = 1'b1; d_rst = 1'b1; d_alub = 1'b1; d_alu = 5'd0; end
            5'b01000: begin d_rwd = 1'b1; d_alub = 1'b1; d_rwe = 1'b1; d_alu = 5'd0; end
            5'b10101: begin d_setx = 1'b1; d_rwe = 1'b1; end
            5'b10110: d_bex = 1'b1;
            default:  d_ill = 1'b1;
        endcase
        if (d_ill) d_alu = 5'd0;
    end

    assign is_md = (opcode == 5'b00000) && (aluop == 5'd6 || aluop == 5'd7);
    assign is_lw = (opcode == 5'b01000);

`ifdef DECODE_HAZARD_EN
    logic            lu_valid;
    logic [REGW-1:0] lu_rd;

    assign hazard = in_valid & lu_valid & (lu_rd != '0) & ((rs == lu_rd) | (rt == lu_rd));
`else
    assign hazard = 1'b0;
`endif

    assign slot_free = ~out_valid | out_ready;
    assign in_ready  = run_q & (state == IDLE) & slot_free & ~hazard & ~flush;
    assign fire      = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign md_start  = fire & is_md;
    assign word_load = fire & ~is_md;
    assign md_load   = (state == MD_WAIT) & (md_cnt == '0) & slot_free & ~flush;

    // Stage FSM, mul/div counter and the registered control word
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            md_cnt    <= '0;
            md_aluop  <= '0;
            md_rd     <= '0;
            md_rs     <= '0;
            md_rt     <= '0;
            run_q     <= 1'b0;
            out_valid <= 1'b0;
            Rwe       <= 1'b0;
            Rst       <= 1'b0;
            ALUinB    <= 1'b0;
            DMwe      <= 1'b0;
            Rwd       <= 1'b0;
            alu_ctrl  <= '0;
            j         <= 1'b0;
            bne       <= 1'b0;
            jal       <= 1'b0;
            jr        <= 1'b0;
            blt       <= 1'b0;
            bex       <= 1'b0;
            setx      <= 1'b0;
            illegal   <= 1'b0;
            rd_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
        end else begin
            run_q <= 1'b1;
            if (flush) begin
                out_valid <= 1'b0;
                md_cnt    <= '0;
                state     <= IDLE;
            end else begin
                if (word_load || md_load) begin
                    out_valid <= 1'b1;
                    Rwe       <= word_load ? d_rwe  : 1'b1;
                    Rst       <= word_load ? d_rst  : 1'b0;
                    ALUinB    <= word_load ? d_alub : 1'b0;
                    DMwe      <= word_load ? d_dmwe : 1'b0;
                    Rwd       <= word_load ? d_rwd  : 1'b0;
                    alu_ctrl  <= word_load ? d_alu  : md_aluop;
                    j         <= word_load ? d_j    : 1'b0;
                    bne       <= word_load ? d_bne  : 1'b0;
                    jal       <= word_load ? d_jal  : 1'b0;
                    jr        <= word_load ? d_jr   : 1'b0;
                    blt       <= word_load ? d_blt  : 1'b0;
                    bex       <= word_load ? d_bex  : 1'b0;
                    setx      <= word_load ? d_setx : 1'b0;
                    illegal   <= word_load ? d_ill  : 1'b0;
                    rd_q      <= word_load ? rd     : md_rd;
                    rs_q      <= word_load ? rs     : md_rs;
                    rt_q      <= word_load ? rt     : md_rt;
                end else if (out_fire) begin
                    out_valid <= 1'b0;
                end
                case (state)
                    IDLE: begin
                        if (md_start) begin
                            md_cnt   <= CNTW'(MD_LAT - 1);
                            md_aluop <= aluop;
                            md_rd    <= rd;
                            md_rs    <= rs;
                            md_rt    <= rt;
                            state    <= MD_WAIT;
                        end else if (hazard) begin
                            state <= STALL;
                        end
                    end
                    MD_WAIT: begin
                        if (md_cnt != '0)   md_cnt <= md_cnt - 1'b1;
                        else if (slot_free) state  <= IDLE;
                    end
                    STALL:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef DECODE_HAZARD_EN
    // Track the destination of the most recently issued load until execute takes it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lu_valid <= 1'b0;
            lu_rd    <= '0;
        end else if (flush) begin
            lu_valid <= 1'b0;
        end else if (word_load && is_lw) begin
            lu_valid <= 1'b1;
            lu_rd    <= rd;
        end else if (out_fire) begin
            lu_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: directed bench for decode_ctrl_pipe with MD_LAT=4.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_decode_ctrl_pipe;

    localparam int REGW = 5;

    // {Rwe,Rst,ALUinB,DMwe,Rwd,j,bne,jal,jr,blt,bex,setx,illegal}
    localparam logic [12:0] W_NONE  = 13'b0000000000000;
    localparam logic [12:0] W_ADDI  = 13'b1010000000000;
    localparam logic [12:0] W_SW    = 13'b0111000000000;
    localparam logic [12:0] W_BNE   = 13'b0100001000000;
    localparam logic [12:0] W_ILL   = 13'b0000000000001;
    localparam logic [12:0] W_RTYPE = 13'b1000000000000;
    localparam logic [12:0] W_LW    = 13'b1010100000000;
    localparam logic [12:0] W_SETX  = 13'b1000000000010;
    localparam logic [12:0] W_JAL   = 13'b1000000100000;

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid, in_ready;
    logic [4:0]      opcode, aluop;
    logic [REGW-1:0] rd, rs, rt;
    logic            flush;
    logic            out_valid, out_ready;
    logic            Rwe, Rst, ALUinB, DMwe, Rwd;
    logic [4:0]      alu_ctrl;
    logic            j, bne, jal, jr, blt, bex, setx;
    logic            md_start, illegal;
    logic [REGW-1:0] rd_q, rs_q, rt_q;
    logic [12:0]     ctrl;

    int checks = 0;
    int errors = 0;
    int waited;

    assign ctrl = {Rwe, Rst, ALUinB, DMwe, Rwd, j, bne, jal, jr, blt, bex, setx, illegal};

    always #5 clock = ~clock;

    decode_ctrl_pipe #(.REGW(REGW), .MD_LAT(4), .CNTW(6)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .aluop(aluop), .rd(rd), .rs(rs), .rt(rt),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .Rwe(Rwe), .Rst(Rst), .ALUinB(ALUinB), .DMwe(DMwe), .Rwd(Rwd),
        .alu_ctrl(alu_ctrl),
        .j(j), .bne(bne), .jal(jal), .jr(jr), .blt(blt), .bex(bex), .setx(setx),
        .md_start(md_start), .illegal(illegal),
        .rd_q(rd_q), .rs_q(rs_q), .rt_q(rt_q)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] op, input logic [4:0] ao,
                                 input logic [REGW-1:0] d, input logic [REGW-1:0] s,
                                 input logic [REGW-1:0] t);
        in_valid = v;
        opcode   = op;
        aluop    = ao;
        rd       = d;
        rs       = s;
        rt       = t;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);

        // reset state and release timing
        repeat (2) @(negedge clock);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_ctrl", ctrl, W_NONE);
        checkOutput("rst_alu", alu_ctrl, 0);
        nextCycle(); reset = 1'b1;
        @(negedge clock); checkOutput("release_ready_0", in_ready, 0);
        nextCycle();
        @(negedge clock); checkOutput("release_ready_1", in_ready, 1);

        // addi issues with latency 1, then async reset mid-stream clears everything
        nextCycle(); applyStimulus(1'b1, 5'b00101, 5'd9, 5'd7, 5'd1, 5'd2);
        @(negedge clock); checkOutput("addi_ready", in_ready, 1);
        nextCycle(); in_valid = 1'b0;
        @(negedge clock);
        checkOutput("addi_valid", out_valid, 1);
        checkOutput("addi_ctrl", ctrl, W_ADDI);
        checkOutput("addi_alu", alu_ctrl, 0);
        checkOutput("addi_rd", rd_q, 7);
        reset = 1'b0; #1;
        checkOutput("midrst_valid", out_valid, 0);
        checkOutput("midrst_ctrl", ctrl, W_NONE);
        checkOutput("midrst_rd", rd_q, 0);
        nextCycle(); reset = 1'b1;
        nextCycle();
        applyStimulus(1'b1, 5'b00101, 5'd0, 5'd8, 5'd0, 5'd0);
        @(negedge clock); checkOutput("addi2_ready", in_ready, 1);

        // sw held for 3 cycles while a new addi waits
        nextCycle(); applyStimulus(1'b1, 5'b00111, 5'd0, 5'd1, 5'd2, 5'd3);
        @(negedge clock); checkOutput("sw_ready", in_ready, 1);
        nextCycle(); applyStimulus(1'b1, 5'b00101, 5'd0, 5'd4, 5'd0, 5'd0); out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checkOutput("hold_ready", in_ready, 0);
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_ctrl", ctrl, W_SW);
            checkOutput("hold_rt", rt_q, 3);
            nextCycle();
        end
        out_ready = 1'b1;
        @(negedge clock); checkOutput("unhold_ready", in_ready, 1);
        nextCycle(); in_valid = 1'b0;
        @(negedge clock);
        checkOutput("after_hold_ctrl", ctrl, W_ADDI);
        checkOutput("after_hold_rd", rd_q, 4);

        // mul: md_start in fire cycle, word visible 5 cycles later
        nextCycle(); applyStimulus(1'b1, 5'b00000, 5'd6, 5'd9, 5'd1, 5'd2);
        @(negedge clock);
        checkOutput("mul_ready", in_ready, 1);
        checkOutput("mul_start", md_start, 1);
        nextCycle(); applyStimulus(1'b1, 5'b00101, 5'd0, 5'd10, 5'd0, 5'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            checkOutput("mdwait_ready", in_ready, 0);
            checkOutput("mdwait_valid", out_valid, 0);
            checkOutput("mdwait_start", md_start, 0);
            nextCycle();
        end
        @(negedge clock);
        checkOutput("mul_valid", out_valid, 1);
        checkOutput("mul_ctrl", ctrl, W_RTYPE);
        checkOutput("mul_alu", alu_ctrl, 6);
        checkOutput("mul_rd", rd_q, 9);
        checkOutput("mul_idle_ready", in_ready, 1);
        nextCycle(); in_valid = 1'b0;
        @(negedge clock); checkOutput("post_mul_rd", rd_q, 10);

        // flush during MD_WAIT with counter at 2
        nextCycle(); applyStimulus(1'b1, 5'b00000, 5'd7, 5'd11, 5'd0, 5'd0);
        @(negedge clock); checkOutput("div_start", md_start, 1);
        nextCycle(); in_valid = 1'b0;
        nextCycle(); flush = 1'b1; applyStimulus(1'b1, 5'b00101, 5'd0, 5'd12, 5'd0, 5'd0);
        @(negedge clock); checkOutput("flush_ready", in_ready, 0);
        nextCycle(); flush = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        checkOutput("flush_md_idle", in_ready, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checkOutput("flush_md_noword", out_valid, 0);
        end

        // flush with a div presented in IDLE: no md_start, not accepted
        nextCycle(); flush = 1'b1; applyStimulus(1'b1, 5'b00000, 5'd7, 5'd13, 5'd0, 5'd0);
        @(negedge clock); checkOutput("flush_no_start", md_start, 0);
        nextCycle(); flush = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        checkOutput("flush_div_dropped", in_ready, 1);
        checkOutput("flush_div_novalid", out_valid, 0);

        // held bne, then flushed
        nextCycle(); applyStimulus(1'b1, 5'b00010, 5'd3, 5'd0, 5'd4, 5'd5); out_ready = 1'b0;
        @(negedge clock); checkOutput("bne_ready", in_ready, 1);
        nextCycle(); in_valid = 1'b0;
        @(negedge clock);
        checkOutput("bne_valid", out_valid, 1);
        checkOutput("bne_ctrl", ctrl, W_BNE);
        checkOutput("bne_alu", alu_ctrl, 1);
        nextCycle(); flush = 1'b1;
        nextCycle(); flush = 1'b0;
        @(negedge clock); checkOutput("bne_flushed", out_valid, 0);
        out_ready = 1'b1;

        // illegal opcodes, setx and jal
        nextCycle(); applyStimulus(1'b1, 5'b11111, 5'd3, 5'd1, 5'd0, 5'd0);
        nextCycle(); applyStimulus(1'b1, 5'b00000, 5'd9, 5'd2, 5'd0, 5'd0);
        @(negedge clock);
        checkOutput("ill_op_ctrl", ctrl, W_ILL);
        checkOutput("ill_op_alu", alu_ctrl, 0);
        checkOutput("ill_op_valid", out_valid, 1);
        nextCycle(); applyStimulus(1'b1, 5'b10101, 5'd4, 5'd3, 5'd0, 5'd0);
        @(negedge clock);
        checkOutput("ill_alu_ctrl", ctrl, W_ILL);
        checkOutput("ill_alu_rd", rd_q, 2);
        nextCycle(); applyStimulus(1'b1, 5'b00011, 5'd2, 5'd31, 5'd0, 5'd0);
        @(negedge clock);
        checkOutput("setx_ctrl", ctrl, W_SETX);
        checkOutput("setx_alu", alu_ctrl, 4);
        nextCycle(); in_valid = 1'b0;
        @(negedge clock);
        checkOutput("jal_ctrl", ctrl, W_JAL);
        checkOutput("jal_alu", alu_ctrl, 2);

        // load-use: lw rd=3 followed by add rs=3
        nextCycle(); applyStimulus(1'b1, 5'b01000, 5'd0, 5'd3, 5'd0, 5'd0);
        @(negedge clock); checkOutput("lw_ready", in_ready, 1);
        nextCycle(); applyStimulus(1'b1, 5'b00000, 5'd0, 5'd6, 5'd3, 5'd1);
        @(negedge clock);
        checkOutput("lw_ctrl", ctrl, W_LW);
`ifdef DECODE_HAZARD_EN
        checkOutput("lu_bubble_ready", in_ready, 0);
`else
        checkOutput("lu_nobubble_ready", in_ready, 1);
`endif
        waited = 0;
        while (!in_ready && waited < 6) begin
            nextCycle();
            @(negedge clock);
            waited++;
        end
        checkOutput("lu_add_accepted", in_ready, 1);
`ifdef DECODE_HAZARD_EN
        checkOutput("lu_bubble_seen", (waited >= 1), 1);
`else
        checkOutput("lu_no_wait", waited, 0);
`endif
        nextCycle(); in_valid = 1'b0;
        @(negedge clock);
        checkOutput("lu_add_ctrl", ctrl, W_RTYPE);
        checkOutput("lu_add_rd", rd_q, 6);

        // same sequence with rd=0: never a bubble
        nextCycle(); applyStimulus(1'b1, 5'b01000, 5'd0, 5'd0, 5'd0, 5'd0);
        nextCycle(); applyStimulus(1'b1, 5'b00000, 5'd0, 5'd7, 5'd0, 5'd0);
        @(negedge clock); checkOutput("lu_r0_ready", in_ready, 1);
        nextCycle(); in_valid = 1'b0;
        @(negedge clock); checkOutput("lu_r0_rd", rd_q, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
